// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared pipeline-control types: hazard FSM state encodings and
//               the default register-specifier width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_MEM_WAIT = 2'd3
    } hz_state_e;

endpackage : pipe_ctrl_pkg

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use comparator between the load in EX and
//               the source registers of the instruction in ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  id_ex_memread_i,
    input  logic [REG_ADDR_W-1:0] id_ex_rt_i,
    input  logic [REG_ADDR_W-1:0] if_id_rs_i,
    input  logic [REG_ADDR_W-1:0] if_id_rt_i,
    input  logic                  if_id_uses_rt_i,
    output logic                  load_use_o
);

    logic w_dest_nonzero;
    logic w_rs_match;
    logic w_rt_match;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign w_dest_nonzero = |id_ex_rt_i;
    assign w_rs_match     = (id_ex_rt_i == if_id_rs_i);
    assign w_rt_match     = (id_ex_rt_i == if_id_rt_i) && if_id_uses_rt_i;

    assign load_use_o = id_ex_memread_i && w_dest_nonzero && (w_rs_match || w_rt_match);

endmodule : load_use_detect

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller: memory-wait hold, taken-branch
//               flush and load-use stall, with optional performance counters
//               enabled by the HAZARD_PERF_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_ready_i,
    input  logic                  ex_branch_taken_i,
    input  logic                  id_ex_memread_i,
    input  logic [REG_ADDR_W-1:0] id_ex_rt_i,
    input  logic [REG_ADDR_W-1:0] if_id_rs_i,
    input  logic [REG_ADDR_W-1:0] if_id_rt_i,
    input  logic                  if_id_uses_rt_i,
    output logic                  pc_write_o,
    output logic                  if_id_write_o,
    output logic                  pipe_hold_o,
    output logic                  id_ex_bubble_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_flush_o,
    output logic                  ex_mem_flush_o,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
    output logic [CNT_W-1:0]      wait_cnt_o
);

    hz_state_e r_state;
    hz_state_e w_state_nxt;
    logic      w_load_use;
    logic      w_lu_enable;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .id_ex_memread_i (id_ex_memread_i),
        .id_ex_rt_i      (id_ex_rt_i),
        .if_id_rs_i      (if_id_rs_i),
        .if_id_rt_i      (if_id_rt_i),
        .if_id_uses_rt_i (if_id_uses_rt_i),
        .load_use_o      (w_load_use)
    );

    // ID is squashed in FLUSH and the bubble already sits in EX in LU_STALL.
    assign w_lu_enable = (r_state != ST_FLUSH) && (r_state != ST_LU_STALL);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = ST_RUN;
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        pipe_hold_o    = 1'b0;
        id_ex_bubble_o = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        if (rst_i) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            pipe_hold_o   = 1'b1;
        end else if (!mem_ready_i) begin
            w_state_nxt   = ST_MEM_WAIT;
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            pipe_hold_o   = 1'b1;
        end else if (ex_branch_taken_i) begin
            w_state_nxt    = ST_FLUSH;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
        end else if (w_load_use && w_lu_enable) begin
            w_state_nxt    = ST_LU_STALL;
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
        end
    end

    assign state_o = r_state;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_wait_cnt;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            if (id_ex_bubble_o && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
            if (if_id_flush_o && (r_flush_cnt != '1))  r_flush_cnt <= r_flush_cnt + C_CNT_ONE;
            if (!mem_ready_i && (r_wait_cnt != '1))    r_wait_cnt  <= r_wait_cnt + C_CNT_ONE;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
    assign wait_cnt_o  = r_wait_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
    assign wait_cnt_o  = '0;
`endif

endmodule : hazard_ctrl

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking scoreboard bench for hazard_ctrl; expected
//               counter values follow the HAZARD_PERF_EN setting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int C_RW = 5;
    localparam int C_CW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            mem_ready;
    logic            br_taken;
    logic            memread;
    logic [C_RW-1:0] ex_rt;
    logic [C_RW-1:0] id_rs;
    logic [C_RW-1:0] id_rt;
    logic            uses_rt;
    logic            pc_write, if_id_write, pipe_hold, bubble;
    logic            f_if_id, f_id_ex, f_ex_mem;
    logic [1:0]      state;
    logic [C_CW-1:0] stall_cnt, flush_cnt, wait_cnt;

    hazard_ctrl #(
        .REG_ADDR_W (C_RW),
        .CNT_W      (C_CW)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .mem_ready_i       (mem_ready),
        .ex_branch_taken_i (br_taken),
        .id_ex_memread_i   (memread),
        .id_ex_rt_i        (ex_rt),
        .if_id_rs_i        (id_rs),
        .if_id_rt_i        (id_rt),
        .if_id_uses_rt_i   (uses_rt),
        .pc_write_o        (pc_write),
        .if_id_write_o     (if_id_write),
        .pipe_hold_o       (pipe_hold),
        .id_ex_bubble_o    (bubble),
        .if_id_flush_o     (f_if_id),
        .id_ex_flush_o     (f_id_ex),
        .ex_mem_flush_o    (f_ex_mem),
        .state_o           (state),
        .stall_cnt_o       (stall_cnt),
        .flush_cnt_o       (flush_cnt),
        .wait_cnt_o        (wait_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           tag;
        logic [6:0]      ctrl;   // {pc_write, if_id_write, hold, bubble, 3 flushes}
        logic [1:0]      st;
        logic [C_CW-1:0] sc, fc, wc;
    } exp_t;

    exp_t            sb_q[$];
    int              n_checks = 0;
    int              n_errors = 0;
    logic [1:0]      m_state;
    logic [C_CW-1:0] m_sc, m_fc, m_wc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [C_CW-1:0] sat_inc(input logic [C_CW-1:0] v);
        return (v == {C_CW{1'b1}}) ? v : v + 16'd1;
    endfunction

    // Drive one cycle of inputs, predict the outputs, then compare at negedge.
    task automatic step(input string tag, input logic r, input logic rdy, input logic br,
                        input logic mr, input logic [C_RW-1:0] ert, input logic [C_RW-1:0] rs,
                        input logic [C_RW-1:0] rt, input logic urt);
        exp_t       e;
        logic       lu;
        logic [1:0] nxt;
        @(posedge clk);
        #1;
        rst = r; mem_ready = rdy; br_taken = br; memread = mr;
        ex_rt = ert; id_rs = rs; id_rt = rt; uses_rt = urt;
        lu = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
        e.tag = tag;
        e.st  = m_state;
`ifdef HAZARD_PERF_EN
        e.sc = m_sc; e.fc = m_fc; e.wc = m_wc;
`else
        e.sc = '0; e.fc = '0; e.wc = '0;
`endif
        nxt = 2'd0;
        if (r) begin
            e.ctrl = 7'b0010000;
            m_sc = '0; m_fc = '0; m_wc = '0;
        end else if (!rdy) begin
            e.ctrl = 7'b0010000; nxt = 2'd3; m_wc = sat_inc(m_wc);
        end else if (br) begin
            e.ctrl = 7'b1100111; nxt = 2'd2; m_fc = sat_inc(m_fc);
        end else if (lu && (m_state == 2'd0 || m_state == 2'd3)) begin
            e.ctrl = 7'b0001000; nxt = 2'd1; m_sc = sat_inc(m_sc);
        end else begin
            e.ctrl = 7'b1100000;
        end
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        check_val({e.tag, ".ctrl"}, {25'd0, pc_write, if_id_write, pipe_hold, bubble,
                                     f_if_id, f_id_ex, f_ex_mem}, {25'd0, e.ctrl});
        check_val({e.tag, ".state"}, {30'd0, state}, {30'd0, e.st});
        check_val({e.tag, ".cnt"}, {stall_cnt, flush_cnt}, {e.sc, e.fc});
        check_val({e.tag, ".wcnt"}, {16'd0, wait_cnt}, {16'd0, e.wc});
        m_state = nxt;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b1; br_taken = 1'b0; memread = 1'b0;
        ex_rt = '0; id_rs = '0; id_rt = '0; uses_rt = 1'b0;
        m_state = 2'd0; m_sc = '0; m_fc = '0; m_wc = '0;

        step("rst0", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("rst1", 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 5'd2, 5'd0, 1'b0);
        idle("idle");

        // lw $2 followed by a user of $2 in rs
        step("lu_rs", 1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 5'd2, 5'd7, 1'b0);
        step("lu_held", 1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 5'd2, 5'd7, 1'b0);
        idle("lu_back");
        // rt match only counts when rt is actually read
        step("rt_unused", 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b0);
        step("rt_used", 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b1);
        idle("rt_back");
        // load to $0 never stalls
        step("zero_dst", 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);

        // branch beats load-use; load-use ignored in FLUSH
        step("br_lu", 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
        step("flush_lu", 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
        idle("flush_back");

        // memory wait during a taken branch, then flush on release
        for (int i = 0; i < 3; i++)
            step("mw_br", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("mw_rel_br", 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        idle("mw_br_back");

        // release from MEM_WAIT with a load-use pending stalls immediately
        step("mw_lu0", 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
        step("mw_rel_lu", 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
        // memory wait wins in LU_STALL
        step("lus_mw", 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0);

        // reset while in MEM_WAIT
        step("mw_again", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("rst_in_mw", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        idle("post_rst");

        // ten separate load-use stalls
        for (int i = 0; i < 10; i++) begin
            step("ten_lu", 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1);
            idle("ten_gap");
        end

        // random mix
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 40) == 0), ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 6) == 0), 1'($urandom),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_hazard_ctrl

`default_nettype wire
